// File: rtl/isp_frame_pkg.sv
// isp_frame_pkg: state encodings and protocol bytes shared by the ISP frame receiver
package isp_frame_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CHK, ST_RESP} frm_state_e;
    typedef enum logic [1:0] {RD_READY, RD_STROBE, RD_WAIT} rd_state_e;
    localparam logic [7:0] SYNC_BYTE = 8'h7E;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/isp_uart_rd_if.sv
// isp_uart_rd_if: one-cycle CSN/OEN read strobe toward the UART core, with an RXRDY release interlock
module isp_uart_rd_if
    import isp_frame_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxrdy_i,
    input  logic [7:0] data_i,
    input  logic       take_en_i,
    output logic       csn_o,
    output logic       oen_o,
    output logic [7:0] byte_o,
    output logic       vld_o
);
    rd_state_e  st_q;
    logic       strobe_q;
    logic [7:0] byte_q;
    logic       vld_q;

    // strobe for one cycle, capture the byte at its end, then hold off until RXRDY drops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q     <= RD_READY;
            strobe_q <= 1'b0;
            byte_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (st_q)
                RD_READY: begin
                    if (rxrdy_i && take_en_i) begin
                        strobe_q <= 1'b1;
                        st_q     <= RD_STROBE;
                    end
                end
                RD_STROBE: begin
                    strobe_q <= 1'b0;
                    byte_q   <= data_i;
                    vld_q    <= 1'b1;
                    st_q     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (!rxrdy_i) st_q <= RD_READY;
                end
                default: st_q <= RD_READY;
            endcase
        end
    end

    assign csn_o  = !strobe_q;
    assign oen_o  = !strobe_q;
    assign byte_o = byte_q;
    assign vld_o  = vld_q;
endmodule

// File: rtl/isp_uart_frame_rx.sv
// isp_uart_frame_rx: ISP packet deframer with checksum, payload skid register and ACK/NAK reply
// Optional inter-byte timeout abort: define ISP_FRAME_TIMEOUT_EN.
module isp_uart_frame_rx
    import isp_frame_pkg::*;
#(
    parameter int MAX_LEN     = 64,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] UART_DATA_OUT,
    input  logic       UART_RXRDY,
    input  logic       UART_TXRDY,
    input  logic       UART_ERR,
    output logic       UART_CSN,
    output logic       UART_OEN,
    output logic       UART_WEN,
    output logic [7:0] UART_DATA_IN,
    output logic [7:0] PL_DATA,
    output logic       PL_VALID,
    input  logic       PL_READY,
    output logic       PL_FIRST,
    output logic       FRAME_DONE,
    output logic       FRAME_OK,
    output logic       BUSY
);
    frm_state_e st_q;
    logic [7:0] cnt_q;
    logic [7:0] acc_q;
    logic       ok_q;
    logic       first_pend_q;
    logic       wr_csn_q;
    logic       wen_q;
    logic       done_q;
    logic [7:0] tx_q;
    logic       pl_valid_q;
    logic [7:0] pl_data_q;
    logic       pl_first_q;
    logic       rd_csn;
    logic       rd_oen;
    logic [7:0] rd_byte;
    logic       rd_vld;
    logic       rx_state;
    logic       tmo_hit;
    logic       abort;
    logic       take_en;
    logic [7:0] sum;

    assign rx_state = (st_q == ST_LEN) || (st_q == ST_PAYLOAD) || (st_q == ST_CHK);
    assign abort    = rx_state && (UART_ERR || tmo_hit);
    assign sum      = acc_q + rd_byte;
    // never start a read that the framer would drop, and keep the skid register single-entry
    assign take_en  = !abort && ((st_q == ST_IDLE) || (st_q == ST_LEN) || (st_q == ST_CHK) ||
                                 ((st_q == ST_PAYLOAD) && !pl_valid_q));

`ifdef ISP_FRAME_TIMEOUT_EN
    logic [31:0] tmo_q;

    // inter-byte idle counter, restarted by every read strobe and outside the receive states
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) tmo_q <= '0;
        else       tmo_q <= (!rx_state || !rd_oen) ? '0 : tmo_q + 32'd1;
    end

    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYC));
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    isp_uart_rd_if u_rd (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .rxrdy_i   (UART_RXRDY),
        .data_i    (UART_DATA_OUT),
        .take_en_i (take_en),
        .csn_o     (rd_csn),
        .oen_o     (rd_oen),
        .byte_o    (rd_byte),
        .vld_o     (rd_vld)
    );

    // framer: sync hunt, length check, payload accumulate, checksum verdict and reply write
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_q         <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            ok_q         <= 1'b0;
            first_pend_q <= 1'b0;
            wr_csn_q     <= 1'b1;
            wen_q        <= 1'b1;
            done_q       <= 1'b0;
            tx_q         <= '0;
            pl_valid_q   <= 1'b0;
            pl_data_q    <= '0;
            pl_first_q   <= 1'b0;
        end else begin
            wr_csn_q <= 1'b1;
            wen_q    <= 1'b1;
            done_q   <= 1'b0;
            if (pl_valid_q && PL_READY) pl_valid_q <= 1'b0;
            if (abort) begin
                ok_q <= 1'b0;
                st_q <= ST_RESP;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        if (rd_vld && rd_byte == SYNC_BYTE) begin
                            acc_q <= '0;
                            ok_q  <= 1'b0;
                            st_q  <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rd_vld) begin
                            if (rd_byte == 8'd0 || int'(rd_byte) > MAX_LEN) begin
                                ok_q <= 1'b0;
                                st_q <= ST_RESP;
                            end else begin
                                cnt_q        <= rd_byte;
                                acc_q        <= rd_byte;
                                first_pend_q <= 1'b1;
                                st_q         <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rd_vld) begin
                            pl_valid_q   <= 1'b1;
                            pl_data_q    <= rd_byte;
                            pl_first_q   <= first_pend_q;
                            first_pend_q <= 1'b0;
                            acc_q        <= sum;
                            cnt_q        <= cnt_q - 8'd1;
                            if (cnt_q == 8'd1) st_q <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rd_vld) begin
                            ok_q <= (sum == 8'd0);
                            st_q <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        if (UART_TXRDY) begin
                            wr_csn_q <= 1'b0;
                            wen_q    <= 1'b0;
                            tx_q     <= ok_q ? ACK_BYTE : NAK_BYTE;
                            done_q   <= 1'b1;
                            st_q     <= ST_IDLE;
                        end
                    end
                    default: st_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign UART_CSN     = rd_csn & wr_csn_q;
    assign UART_OEN     = rd_oen;
    assign UART_WEN     = wen_q;
    assign UART_DATA_IN = tx_q;
    assign PL_DATA      = pl_data_q;
    assign PL_VALID     = pl_valid_q;
    assign PL_FIRST     = pl_first_q;
    assign FRAME_DONE   = done_q;
    assign FRAME_OK     = ok_q;
    assign BUSY         = (st_q != ST_IDLE);
endmodule
